// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       div_op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output start_i, div_op_i, a_i, b_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, div_op_i, a_i, b_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved at acceptance.
module div_unit #(
    parameter int WIDTH = 32
) (
    input logic       clk_i,
    input logic       reset_i,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_op;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic             w_div0;
    logic             w_ovf;
    logic [WIDTH-1:0] w_spec_res;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_fit;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quot_nx;
    logic [WIDTH-1:0] w_fin;

    assign w_signed = ~bus.div_op_i[0];
    assign w_a_neg  = w_signed & bus.a_i[WIDTH-1];
    assign w_b_neg  = w_signed & bus.b_i[WIDTH-1];
    assign w_a_abs  = w_a_neg ? -bus.a_i : bus.a_i;
    assign w_b_abs  = w_b_neg ? -bus.b_i : bus.b_i;
    assign w_div0   = (bus.b_i == '0);
    assign w_ovf    = w_signed
                    & (bus.a_i == {1'b1, {(WIDTH-1){1'b0}}})
                    & (bus.b_i == '1);

    always_comb begin
        w_spec_res = '0;
        if (w_div0)
            w_spec_res = bus.div_op_i[1] ? bus.a_i : '1;
        else
            w_spec_res = bus.div_op_i[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end

    // The shifted partial remainder can reach 33 bits; the trial's MSB is its sign.
    assign w_sh      = {r_rem, r_quot[WIDTH-1]};
    assign w_trial   = w_sh - {1'b0, r_dvs};
    assign w_fit     = ~w_trial[WIDTH];
    assign w_rem_nx  = w_fit ? w_trial[WIDTH-1:0] : w_sh[WIDTH-1:0];
    assign w_quot_nx = {r_quot[WIDTH-2:0], w_fit};

    always_comb begin
        w_fin = '0;
        if (r_op[1])
            w_fin = r_neg_r ? -w_rem_nx : w_rem_nx;
        else
            w_fin = r_neg_q ? -w_quot_nx : w_quot_nx;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_dvs    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else if (bus.flush_i) begin
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start_i) begin
                        r_op    <= bus.div_op_i;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_rem   <= '0;
                        r_quot  <= w_a_abs;
                        r_dvs   <= w_b_abs;
                        r_cnt   <= '0;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_spec_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_rem  <= w_rem_nx;
                    r_quot <= w_quot_nx;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_result <= w_fin;
                        r_state  <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o   = (r_state == S_CALC);
    assign bus.done_o   = (r_state == S_DONE);
    assign bus.result_o = r_result;
endmodule

// File: tb/tb_div_unit.sv
// Random and directed checks of div_unit against an arithmetic reference model.
module tb_div_unit;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return op[1] ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit is_special(input logic [1:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'd0) ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit b2b, input int poke,
                         output logic [31:0] res, output int lat,
                         output int nbusy);
        if (!b2b) @(negedge clk);
        bus.start_i  = 1'b1;
        bus.div_op_i = op;
        bus.a_i      = a;
        bus.b_i      = b;
        @(posedge clk);
        #1;
        bus.start_i  = 1'b0;
        bus.div_op_i = 2'($urandom);
        bus.a_i      = $urandom;
        bus.b_i      = $urandom;
        nbusy = 0;
        for (lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            if (bus.done_o) break;
            if (bus.busy_o) nbusy++;
            if (poke > 0 && lat == poke) bus.start_i = 1'b1;
            if (poke > 0 && lat == poke + 1) bus.start_i = 1'b0;
        end
        res = bus.result_o;
    endtask

    task automatic check_op(input string tag, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input bit b2b, input int poke,
                            input logic [31:0] exp);
        logic [31:0] res;
        int lat;
        int nbusy;
        bit sp;
        sp = is_special(op, a, b);
        do_op(op, a, b, b2b, poke, res, lat, nbusy);
        chk({tag, "_res"}, res, exp);
        chk({tag, "_lat"}, 32'(lat), sp ? 32'd1 : 32'd33);
        chk({tag, "_busy"}, 32'(nbusy), sp ? 32'd0 : 32'd32);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corner [5];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'hFFFF_FFFF;
        case ($urandom_range(0, 3))
            0:       return corner[$urandom_range(0, 4)];
            1:       return 32'($urandom_range(0, 15));
            2:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        int          seen;
        n_chk        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.div_op_i = 2'b00;
        bus.a_i      = '0;
        bus.b_i      = '0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_res", bus.result_o, 32'd0);
        rst = 1'b0;

        check_op("divu", 2'b01, 32'd100, 32'd7, 1'b0, 0, 32'd14);
        @(negedge clk);
        chk("done_1cyc", 32'(bus.done_o), 32'd0);
        chk("idle_busy", 32'(bus.busy_o), 32'd0);
        check_op("remu", 2'b11, 32'd100, 32'd7, 1'b0, 0, 32'd2);
        check_op("rem_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 0,
                 32'hFFFF_FFFF);
        check_op("div_neg", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0, 0,
                 32'hFFFF_FFFD);
        check_op("div_nn", 2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 0,
                 32'd3);
        check_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0,
                 32'h8000_0000);
        check_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0,
                 32'd0);
        check_op("divu_z", 2'b01, 32'h1234, 32'd0, 1'b0, 0, 32'hFFFF_FFFF);
        check_op("remu_z", 2'b11, 32'h1234, 32'd0, 1'b0, 0, 32'h1234);
        check_op("poke", 2'b01, 32'd1000, 32'd3, 1'b0, 5, 32'd333);
        check_op("b2b", 2'b10, 32'd1001, 32'd10, 1'b1, 0, 32'd1);

        // Flush at iteration 10 with a simultaneous start that must be dropped.
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.div_op_i = 2'b01;
        bus.a_i      = 32'd5000;
        bus.b_i      = 32'd9;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("fl_busy_pre", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        seen = 0;
        @(negedge clk);
        chk("fl_busy", 32'(bus.busy_o), 32'd0);
        chk("fl_res", bus.result_o, 32'd1);
        repeat (40) begin
            if (bus.done_o || bus.busy_o) seen++;
            @(negedge clk);
        end
        chk("fl_quiet", 32'(seen), 32'd0);

        // Asynchronous reset between edges during CALC.
        bus.start_i  = 1'b1;
        bus.div_op_i = 2'b00;
        bus.a_i      = 32'd77777;
        bus.b_i      = 32'd13;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(bus.busy_o), 32'd0);
        chk("ar_done", 32'(bus.done_o), 32'd0);
        chk("ar_res", bus.result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            op = 2'($urandom);
            a  = pick();
            b  = pick();
            check_op("rnd", op, a, b, 1'($urandom), 0, model(op, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
